if_fetch_unit: RTL

Instruction-fetch controller for the RV32IM 5-stage pipeline. It is the requesting end of the instruction-memory read port: it drives the fetch address into the synchronous, one-cycle-latency instruction memory, pairs each returned word with its PC, and presents `{pc, instr, valid}` to the IF/ID boundary. It handles boot after reset, ID-stage stalls, and EX-stage branch/jump redirects, and counts delivered instructions.

---
 rtl/if_fetch_unit_pkg.sv | 20 ++
 rtl/if_fetch_unit.sv | 68 ++++++
 2 files changed

// File: rtl/if_fetch_unit_pkg.sv
// Shared RV32 pipeline constants: word width, canonical NOP, boot address and fetch FSM encoding.
package if_fetch_unit_pkg;

  localparam int XLEN = 32;

  localparam logic [XLEN-1:0] NOP_INSTR        = 32'h0000_0013;
  localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 32'h0000_0000;
  localparam logic [XLEN-1:0] PC_STEP          = 32'd4;

  typedef enum logic {
    BOOT = 1'b0,
    RUN  = 1'b1
  } fetch_state_t;

  // Instruction addresses are word aligned; low bits of a redirect are dropped, never faulted.
  function automatic logic [XLEN-1:0] align_pc(input logic [XLEN-1:0] addr);
    return {addr[XLEN-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/if_fetch_unit.sv
// IF stage: drives imem address, pairs the returned word with its PC; one instruction per cycle,
// output valid one edge after the address is issued; stall re-reads the same word, redirect squashes one cycle.
module if_fetch_unit
  import if_fetch_unit_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic            clk,
  input  logic            rst,
  output logic [XLEN-1:0] imem_pc,
  input  logic [XLEN-1:0] imem_instr,
  input  logic            stall,
  input  logic            branch_taken,
  input  logic [XLEN-1:0] branch_target,
  output logic [XLEN-1:0] if_pc,
  output logic [XLEN-1:0] if_instr,
  output logic            if_valid,
  output logic [XLEN-1:0] fetch_count
);

  fetch_state_t    state;
  logic [XLEN-1:0] req_pc;
  logic            resp_valid;

  // Next address presented to memory; branch beats stall so a stalled wrong-path word is dropped.
  always_comb begin
    imem_pc  = RESET_PC;
    if_valid = 1'b0;
    if (state == RUN) begin
      if_valid = resp_valid & ~branch_taken;
      if (branch_taken) begin
        imem_pc = align_pc(branch_target);
      end else if (stall) begin
        imem_pc = req_pc;
      end else begin
        imem_pc = req_pc + PC_STEP;
      end
    end
  end

  assign if_pc    = req_pc;
  assign if_instr = if_valid ? imem_instr : NOP_INSTR;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= BOOT;
      req_pc      <= RESET_PC;
      resp_valid  <= 1'b0;
      fetch_count <= '0;
    end else begin
      case (state)
        BOOT: begin
          req_pc     <= RESET_PC;
          resp_valid <= 1'b1;
          state      <= RUN;
        end
        default: begin
          req_pc     <= imem_pc;
          resp_valid <= 1'b1;
        end
      endcase
      if (if_valid && !stall) begin
        fetch_count <= fetch_count + 32'd1;
      end
    end
  end

endmodule
